memory_port_arbiter: RTL and testbench

Two-requester arbiter that shares the single memory_controller port between the CPU core (requester 0) and a secondary master (requester 1, e.g. program loader or debug DMA). It serialises single-word read/write transactions with round-robin fairness, an optional ownership lock for bursts, and read-data return routing. It sits between the requesters and memory_controller.

---
 rtl/memory_port_arbiter_if.sv | 42 ++++
 rtl/memory_port_arbiter.sv | 123 ++++++++++++
 tb/tb_memory_port_arbiter.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/memory_port_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the memory port.
// The arbiter uses the slave view; requesters and memory use the master view.
interface memory_port_arbiter_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
);
  // requester side
  logic                  req0;
  logic                  req1;
  logic                  we0;
  logic                  we1;
  logic [ADDR_WIDTH-1:0] addr0;
  logic [ADDR_WIDTH-1:0] addr1;
  logic [DATA_WIDTH-1:0] wdata0;
  logic [DATA_WIDTH-1:0] wdata1;
  logic                  lock1;
  logic                  gnt0;
  logic                  gnt1;
  logic                  rvalid0;
  logic                  rvalid1;
  logic [DATA_WIDTH-1:0] rdata;
  logic [CNT_WIDTH-1:0]  gnt_cnt0;
  logic [CNT_WIDTH-1:0]  gnt_cnt1;
  // memory side
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, lock1, mem_rdata,
    output gnt0, gnt1, rvalid0, rvalid1, rdata, gnt_cnt0, gnt_cnt1,
           mem_addr, mem_wdata, mem_we
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, lock1, mem_rdata,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata, gnt_cnt0, gnt_cnt1,
           mem_addr, mem_wdata, mem_we
  );
endinterface

// File: rtl/memory_port_arbiter.sv
// Two-requester round-robin arbiter for the single memory controller port.
// Requester 0 is the CPU core, requester 1 a secondary master that may lock
// ownership for bursts. Each transaction is one ACCESS cycle, plus one RDWAIT
// cycle for reads while the synchronous memory returns data.
module memory_port_arbiter #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  memory_port_arbiter_if.slave bus
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RDWAIT = 2'd2;

  typedef struct packed {
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
  } req_t;

  req_t [1:0]                 rq;
  logic [1:0]                 req;
  logic [1:0]                 state;
  logic [1:0]                 state_nxt;
  logic                       owner;      // 1 = requester 1 owns the port
  logic                       owner_nxt;
  logic                       last;       // requester served most recently
  logic                       lock_held;
  logic [1:0][CNT_WIDTH-1:0]  cnt;
  req_t                       own;
  logic                       pick1;
  logic                       any_sel;
  logic                       in_access;
  logic                       in_rdwait;

  assign req   = {bus.req1, bus.req0};
  assign rq[0] = {bus.we0, bus.addr0, bus.wdata0};
  assign rq[1] = {bus.we1, bus.addr1, bus.wdata1};

  // Owner's request is muxed from the registered owner, never from req.
  assign own = rq[owner];

  // Requester 1 wins when alone, when 0 was served last, or while locked.
  assign pick1   = req[1] & (lock_held | ~req[0] | ~last);
  // A held lock shuts requester 0 out entirely, even if 1 is not asking.
  assign any_sel = lock_held ? req[1] : |req;

  assign in_access = (state == ACCESS);
  assign in_rdwait = (state == RDWAIT);

  // Next-state and owner selection.
  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    case (state)
      IDLE: begin
        if (any_sel) begin
          state_nxt = ACCESS;
          owner_nxt = pick1;
        end
      end
      ACCESS:  state_nxt = own.we ? IDLE : RDWAIT;
      RDWAIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State and owner registers; reset aborts any transaction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      owner <= 1'b0;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
    end
  end

  // Round-robin history and burst lock. Reset treats requester 1 as last
  // served so requester 0 is favoured first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last      <= 1'b1;
      lock_held <= 1'b0;
    end else begin
      if (in_access)
        last <= owner;
      if (in_access && owner && bus.lock1)
        lock_held <= 1'b1;
      else if ((state == IDLE || in_access) && !bus.lock1)
        lock_held <= 1'b0;
    end
  end

  // Saturating per-requester grant counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (in_access && (owner == i[0]) && (cnt[i] != {CNT_WIDTH{1'b1}}))
          cnt[i] <= cnt[i] + 1'b1;
      end
    end
  end

  // Outputs decode registered state only; no path from req to gnt.
  assign bus.gnt0      = in_access & ~owner;
  assign bus.gnt1      = in_access &  owner;
  assign bus.rvalid0   = in_rdwait & ~owner;
  assign bus.rvalid1   = in_rdwait &  owner;
  assign bus.rdata     = in_rdwait ? bus.mem_rdata : '0;
  assign bus.mem_we    = in_access & own.we;
  assign bus.mem_addr  = in_access ? own.addr  : '0;
  assign bus.mem_wdata = in_access ? own.wdata : '0;
  assign bus.gnt_cnt0  = cnt[0];
  assign bus.gnt_cnt1  = cnt[1];

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Bench for memory_port_arbiter: directed scenarios followed by randomized
// traffic scored against a transaction-level arbitration/memory model.
module tb_memory_port_arbiter;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam int CW = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  memory_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();
  memory_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(2))  sbus ();

  memory_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave)
  );

  memory_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(2)) dut_sat (
    .clk(clk), .rst(rst), .bus(sbus.slave)
  );

  // synchronous memory: data one cycle after address
  logic [DW-1:0] ram [0:255];
  always @(posedge clk) begin
    if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= ram[bus.mem_addr];
  end
  assign sbus.mem_rdata = '0;

  int n_cmp = 0;
  int n_err = 0;

  // reference model state
  logic [DW-1:0] mdl_mem [int];
  bit            pend    [2];
  bit            r_we    [2];
  logic [AW-1:0] r_addr  [2];
  logic [DW-1:0] r_wdata [2];
  int            last_srv;
  longint        mcnt    [2];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.req0 = 0; bus.req1 = 0; bus.we0 = 0; bus.we1 = 0;
    bus.addr0 = '0; bus.addr1 = '0; bus.wdata0 = '0; bus.wdata1 = '0; bus.lock1 = 0;
    sbus.req0 = 0; sbus.req1 = 0; sbus.we0 = 0; sbus.we1 = 0;
    sbus.addr0 = '0; sbus.addr1 = '0; sbus.wdata0 = '0; sbus.wdata1 = '0; sbus.lock1 = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
    @(negedge clk);
  endtask

  // Wait (bounded) for a grant on the main or saturation instance.
  task automatic wait_gnt(input bit sat, output int who, output int lat);
    who = -1;
    lat = 0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (sat ? sbus.gnt0 : (bus.gnt0 || bus.gnt1)) begin
        who = sat ? 0 : (bus.gnt1 ? 1 : 0);
        lat = i;
        check("gnt_excl", {63'd0, bus.gnt0 & bus.gnt1}, 64'd0);
        break;
      end
    end
    check("gnt_seen", {63'd0, who >= 0}, 64'd1);
  endtask

  task automatic drive_main();
    bus.req0 = pend[0]; bus.we0 = r_we[0]; bus.addr0 = r_addr[0]; bus.wdata0 = r_wdata[0];
    bus.req1 = pend[1]; bus.we1 = r_we[1]; bus.addr1 = r_addr[1]; bus.wdata1 = r_wdata[1];
  endtask

  task automatic new_req(input int i);
    pend[i]    = 1;
    r_we[i]    = ($urandom_range(0, 1) == 1);
    r_addr[i]  = AW'($urandom_range(0, 15));
    r_wdata[i] = $urandom;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int who, lat, exp;
    clear_inputs();
    rst = 1;
    repeat (2) @(negedge clk);

    // reset values
    check("rst_gnt",    {bus.gnt0, bus.gnt1, bus.rvalid0, bus.rvalid1}, 0);
    check("rst_mem_we", bus.mem_we, 0);
    check("rst_addr",   bus.mem_addr, 0);
    check("rst_wdata",  bus.mem_wdata, 0);
    check("rst_rdata",  bus.rdata, 0);
    check("rst_cnt",    {bus.gnt_cnt0, bus.gnt_cnt1}, 0);
    rst = 0;
    @(negedge clk);

    // single write from requester 0
    bus.req0 = 1; bus.we0 = 1; bus.addr0 = 8'h10; bus.wdata0 = 32'hDEADBEEF;
    wait_gnt(0, who, lat);
    check("wr_who", who, 0);
    check("wr_lat", lat, 1);
    check("wr_mem_we", bus.mem_we, 1);
    check("wr_addr", bus.mem_addr, 8'h10);
    check("wr_wdata", bus.mem_wdata, 32'hDEADBEEF);
    @(negedge clk);
    bus.req0 = 0;
    check("wr_idle_we", bus.mem_we, 0);
    check("wr_cnt0", bus.gnt_cnt0, 1);

    // read of the same word by requester 1
    bus.req1 = 1; bus.we1 = 0; bus.addr1 = 8'h10;
    wait_gnt(0, who, lat);
    check("rd_who", who, 1);
    check("rd_lat", lat, 1);
    check("rd_mem_we", bus.mem_we, 0);
    check("rd_addr", bus.mem_addr, 8'h10);
    check("rd_early_rvalid", bus.rvalid1, 0);
    @(negedge clk);
    check("rd_rvalid1", bus.rvalid1, 1);
    check("rd_rvalid0", bus.rvalid0, 0);
    check("rd_rdata", bus.rdata, 32'hDEADBEEF);
    check("rd_gnt_low", bus.gnt1, 0);
    bus.req1 = 0;
    @(negedge clk);
    check("rd_rvalid_pulse", bus.rvalid1, 0);

    // contention: both write continuously, grants alternate from 0
    do_reset();
    bus.req0 = 1; bus.we0 = 1; bus.addr0 = 8'h20; bus.wdata0 = 32'h0000_0A0A;
    bus.req1 = 1; bus.we1 = 1; bus.addr1 = 8'h21; bus.wdata1 = 32'h0000_B1B1;
    for (int k = 0; k < 8; k++) begin
      wait_gnt(0, who, lat);
      check("rr_who", who, k % 2);
      check("rr_lat", lat, (k == 0) ? 1 : 2);
      check("rr_addr", bus.mem_addr, (k % 2 == 0) ? 8'h20 : 8'h21);
    end
    @(negedge clk);
    bus.req0 = 0; bus.req1 = 0;
    check("rr_cnt0", bus.gnt_cnt0, 4);
    check("rr_cnt1", bus.gnt_cnt1, 4);

    // lock: requester 1 keeps the port for 4 transactions while 0 waits
    bus.req1 = 1; bus.we1 = 1; bus.addr1 = 8'h31; bus.lock1 = 1;
    for (int k = 0; k < 4; k++) begin
      wait_gnt(0, who, lat);
      check("lock_who", who, 1);
      if (k == 0) begin
        bus.req0 = 1; bus.we0 = 1; bus.addr0 = 8'h30;
      end
      if (k == 3) bus.lock1 = 0;
    end
    wait_gnt(0, who, lat);
    check("unlock_who", who, 0);
    @(negedge clk);
    bus.req0 = 0; bus.req1 = 0;
    check("lock_cnt0", bus.gnt_cnt0, 5);
    check("lock_cnt1", bus.gnt_cnt1, 8);

    // reset during RDWAIT
    bus.req0 = 1; bus.we0 = 0; bus.addr0 = 8'h10;
    wait_gnt(0, who, lat);
    check("rstrd_who", who, 0);
    @(posedge clk);
    #2;
    rst = 1;
    #1;
    check("rstrd_rvalid", {bus.rvalid0, bus.rvalid1}, 0);
    check("rstrd_gnt", {bus.gnt0, bus.gnt1}, 0);
    check("rstrd_cnt", {bus.gnt_cnt0, bus.gnt_cnt1}, 0);
    check("rstrd_rdata", bus.rdata, 0);
    bus.req0 = 0;
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    bus.req0 = 1; bus.we0 = 0; bus.addr0 = 8'h10;
    wait_gnt(0, who, lat);
    check("rstrd_again_lat", lat, 1);
    @(negedge clk);
    check("rstrd_again_rvalid", bus.rvalid0, 1);
    check("rstrd_again_rdata", bus.rdata, 32'hDEADBEEF);
    @(negedge clk);
    bus.req0 = 0;
    check("rstrd_again_cnt0", bus.gnt_cnt0, 1);

    // reset during a write ACCESS aborts the write strobe
    bus.req1 = 1; bus.we1 = 1; bus.addr1 = 8'h40; bus.wdata1 = 32'h1234_5678;
    wait_gnt(0, who, lat);
    check("abort_mem_we_before", bus.mem_we, 1);
    rst = 1;
    #1;
    check("abort_mem_we", bus.mem_we, 0);
    check("abort_mem_addr", bus.mem_addr, 0);
    check("abort_gnt1", bus.gnt1, 0);
    bus.req1 = 0;
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    check("abort_cnt1", bus.gnt_cnt1, 0);

    // saturation with a 2-bit counter
    sbus.req0 = 1; sbus.we0 = 1; sbus.addr0 = 8'h05; sbus.wdata0 = 32'h1;
    for (int g = 0; g < 5; g++) begin
      wait_gnt(1, who, lat);
      check("sat_cnt_pre", sbus.gnt_cnt0, (g > 3) ? 3 : g);
    end
    @(negedge clk);
    sbus.req0 = 0;
    check("sat_cnt0", sbus.gnt_cnt0, 3);

    // randomized traffic against the transaction-level model
    do_reset();
    last_srv = 1;
    mcnt[0] = 0; mcnt[1] = 0;
    pend[0] = 0; pend[1] = 0;
    for (int i = 0; i < 2; i++) begin
      r_we[i] = 0; r_addr[i] = '0; r_wdata[i] = '0;
    end
    for (int t = 0; t < 80; t++) begin
      for (int i = 0; i < 2; i++)
        if (!pend[i] && $urandom_range(0, 1) == 1) new_req(i);
      if (!pend[0] && !pend[1]) new_req(int'($urandom_range(0, 1)));
      drive_main();
      // both pending: whoever was not served last; otherwise the lone one
      exp = (pend[0] && pend[1]) ? ((last_srv == 0) ? 1 : 0) : (pend[1] ? 1 : 0);
      wait_gnt(0, who, lat);
      check("rnd_who", who, exp);
      check("rnd_lat", lat, 1);
      check("rnd_we", bus.mem_we, r_we[exp]);
      check("rnd_addr", bus.mem_addr, r_addr[exp]);
      if (r_we[exp]) check("rnd_wdata", bus.mem_wdata, r_wdata[exp]);
      last_srv = exp;
      mcnt[exp]++;
      if (r_we[exp]) begin
        mdl_mem[int'(r_addr[exp])] = r_wdata[exp];
      end else begin
        @(negedge clk);
        check("rnd_rvalid", {bus.rvalid1, bus.rvalid0}, (exp == 1) ? 2'b10 : 2'b01);
        if (mdl_mem.exists(int'(r_addr[exp])))
          check("rnd_rdata", bus.rdata, mdl_mem[int'(r_addr[exp])]);
      end
      @(negedge clk);
      pend[exp] = 0;
      drive_main();
      check("rnd_cnt0", bus.gnt_cnt0, mcnt[0]);
      check("rnd_cnt1", bus.gnt_cnt1, mcnt[1]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
